// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Index width that never collapses to zero bits when there is a single chunk.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: a + b + ci computed one CHUNK-bit slice per clock behind valid/ready.
// Optional subtract mode (a + ~b + ci) enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = clog2_safe(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   sum_q, sum_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic             slice_cout;
    logic             b_inv;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_inv = sub;
`else
    assign b_inv = 1'b0;
`endif

    assign slice_a = a_q[32'(idx_q) * CHUNK +: CHUNK];
    assign slice_b = b_q[32'(idx_q) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .x   (slice_a),
        .y   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtract mode stores the complemented operand so CALC stays add-only.
                    b_d     = b_inv ? ~b : b;
                    idx_d   = '0;
                    carry_d = ci;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[32'(idx_q) * CHUNK +: CHUNK] = slice_s;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d[WIDTH] = slice_cout;
                    idx_d        = '0;
                    state_d      = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed table, random ops, backpressure, reset abort.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_drv, b_drv;
    logic        ci_drv, sub_drv, out_ready;
    logic [3:0]  iv, ir, ov;
    logic [4:0]  s0;
    logic [32:0] s1;
    logic [8:0]  s2, s3;

    int n_checks = 0;
    int n_pass   = 0;

    seq_chunk_adder #(.WIDTH(4), .CHUNK(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_drv[3:0]), .b(b_drv[3:0]), .ci(ci_drv),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sub_drv),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .sum(s0)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_drv), .b(b_drv), .ci(ci_drv),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sub_drv),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .sum(s1)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .ci(ci_drv),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sub_drv),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .sum(s2)
    );

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_sub (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .ci(ci_drv), .sub(sub_drv),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(s3)
    );
    localparam int NINST = 4;
`else
    assign ir[3] = 1'b1;
    assign ov[3] = 1'b0 & iv[3];
    assign s3    = '0;
    localparam int NINST = 3;
`endif

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [32:0] exp;
    } vec_t;

    function automatic int wid(input int inst);
        case (inst)
            0:       return 4;
            1:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int nchunk(input int inst);
        case (inst)
            0:       return 2;
            1:       return 8;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [32:0] get_sum(input int inst);
        case (inst)
            0:       return 33'(s0);
            1:       return s1;
            2:       return 33'(s2);
            default: return 33'(s3);
        endcase
    endfunction

    // Reference: plain integer arithmetic on the operand width.
    function automatic logic [32:0] model(input int inst, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub);
        longint unsigned m, av, bv;
        m  = (64'd1 << wid(inst)) - 64'd1;
        av = {32'd0, a} & m;
        bv = sub ? (~{32'd0, b}) & m : {32'd0, b} & m;
        return 33'(av + bv + {63'd0, ci});
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub,
                          output logic [32:0] res, output int lat);
        int j;
        j = 0;
        while (ir[inst] !== 1'b1 && j < 50) begin
            @(negedge clk);
            j++;
        end
        a_drv = a; b_drv = b; ci_drv = ci; sub_drv = sub;
        iv[inst] = 1'b1;
        @(negedge clk);
        // Scramble operands during CALC; they must be ignored.
        iv[inst] = 1'b0;
        a_drv = $urandom; b_drv = $urandom; ci_drv = 1'($urandom);
        lat = 0;
        while (ov[inst] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = get_sum(inst);
        @(negedge clk);
    endtask

    vec_t        vecs[$];
    logic [32:0] res, exp;
    logic [31:0] ra, rb;
    logic        rc, rs;
    int          lat, inst, j, pulses;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; iv = '0; a_drv = '0; b_drv = '0; ci_drv = 1'b0; sub_drv = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 33'(ir[1]), 33'd1);
        check("reset_out_valid", 33'(ov[1]), 33'd0);
        check("reset_sum", s1, 33'd0);
        check("reset_sum_w4", 33'(s0), 33'd0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{0, 32'd3, 32'd4, 1'b0, 1'b0, 33'd7});
        vecs.push_back('{0, 32'd2, 32'd5, 1'b1, 1'b0, 33'd8});
        vecs.push_back('{0, 32'd7, 32'd7, 1'b1, 1'b0, 33'd15});
        vecs.push_back('{0, 32'd15, 32'd15, 1'b1, 1'b0, 33'd31});
        vecs.push_back('{1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 33'h1_0000_0000});
        vecs.push_back('{2, 32'h80, 32'h80, 1'b0, 1'b0, 33'h100});
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        vecs.push_back('{3, 32'd5, 32'd7, 1'b1, 1'b1, 33'h0FE});
        vecs.push_back('{3, 32'd7, 32'd5, 1'b1, 1'b1, 33'h102});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, res, lat);
            check($sformatf("vec%0d_sum", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 33'(lat), 33'(nchunk(vecs[i].inst)));
        end

        for (int i = 0; i < 40; i++) begin
            inst = int'($urandom_range(0, NINST - 1));
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            rs = (inst == 3) ? 1'($urandom) : 1'b0;
            run_op(inst, ra, rb, rc, rs, res, lat);
            check($sformatf("rand%0d_sum", i), res, model(inst, ra, rb, rc, rs));
            check($sformatf("rand%0d_latency", i), 33'(lat), 33'(nchunk(inst)));
        end

        // Backpressure: result must hold while out_ready is low, and no new accept.
        out_ready = 1'b0;
        ra = $urandom; rb = $urandom;
        a_drv = ra; b_drv = rb; ci_drv = 1'b1; sub_drv = 1'b0; iv[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        j = 0;
        while (ov[1] !== 1'b1 && j < 100) begin
            @(negedge clk);
            j++;
        end
        check("bp_latency", 33'(j), 33'd8);
        exp = model(1, ra, rb, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_sum", s1, exp);
            check("bp_out_valid", 33'(ov[1]), 33'd1);
            check("bp_in_ready", 33'(ir[1]), 33'd0);
            a_drv = $urandom; b_drv = $urandom; iv[1] = 1'b1;
            @(negedge clk);
        end
        // Output handshake with in_valid still high must not accept in the same cycle.
        out_ready = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        check("bp_release_in_ready", 33'(ir[1]), 33'd1);
        check("bp_release_out_valid", 33'(ov[1]), 33'd0);

        // Reset during CALC cycle 3, with in_valid high during reset.
        ra = $urandom; rb = $urandom;
        a_drv = ra; b_drv = rb; ci_drv = 1'b0; iv[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; iv[1] = 1'b1; a_drv = $urandom;
        @(negedge clk);
        rst_n = 1'b1; iv[1] = 1'b0;
        check("rst_in_ready", 33'(ir[1]), 33'd1);
        check("rst_out_valid", 33'(ov[1]), 33'd0);
        check("rst_sum", s1, 33'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov[1] === 1'b1) pulses++;
        end
        check("rst_no_pulse", 33'(pulses), 33'd0);

        ra = $urandom; rb = $urandom;
        run_op(1, ra, rb, 1'b1, 1'b0, res, lat);
        check("post_rst_sum", res, model(1, ra, rb, 1'b1, 1'b0));
        check("post_rst_latency", 33'(lat), 33'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
